song_player_ctrl: RTL and testbench

SONG_PLAYER_CTRL -- requirements
Module: song_player_ctrl

---
 rtl/song_player_ctrl.sv | 147 ++++++++++++++
 tb/tb_song_player_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/song_player_ctrl.sv
`default_nettype none
// ============================================================================
// song_player_ctrl : steps a note chart from a synchronous ROM, one entry per note
// Revision 1.0
// ============================================================================
module song_player_ctrl #(
  parameter int TICK_DIV = 2500000,
  parameter int ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        song_id,
  input  logic              pause,
  input  logic              abort,
  output logic [ROM_AW+1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              note_valid,
  output logic [2:0]        note_lanes,
  output logic              busy,
  output logic              finish,
  output logic [ROM_AW-1:0] note_idx
);

  localparam int                DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [ROM_AW-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          song_q, song_d;
  logic [ROM_AW-1:0]   idx_q, idx_d;
  logic [ROM_AW+1:0]   addr_q, addr_d;
  logic [2:0]          lanes_q, lanes_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [4:0]          dur_q, dur_d;
  logic [ROM_AW-1:0]   idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    lanes_d    = lanes_q;
    div_d      = div_q;
    dur_d      = dur_q;
    note_valid = 1'b0;
    finish     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && (song_id != 2'd0)) begin
          song_d  = song_id;
          idx_d   = '0;
          addr_d  = {song_id, {ROM_AW{1'b0}}};
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (rom_data == 8'h00) begin
          state_d = S_DONE;
        end else begin
          note_valid = 1'b1;
          lanes_d    = rom_data[7:5];
          // A zero duration on a real note still plays for one tick
          dur_d      = (rom_data[4:0] == 5'd0) ? 5'd1 : rom_data[4:0];
          div_d      = '0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!pause) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (dur_q == 5'd1) begin
              if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
              end else begin
                idx_d   = idx_inc;
                addr_d  = {song_q, idx_inc};
                state_d = S_FETCH;
              end
            end else begin
              dur_d = dur_q - 5'd1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        finish  = 1'b1;
        lanes_d = 3'b000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every other transition, including a finish in DONE
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      lanes_d    = 3'b000;
      div_d      = '0;
      dur_d      = 5'd0;
      note_valid = 1'b0;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      song_q  <= 2'd0;
      idx_q   <= '0;
      addr_q  <= '0;
      lanes_q <= 3'b000;
      div_q   <= '0;
      dur_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      lanes_q <= lanes_d;
      div_q   <= div_d;
      dur_q   <= dur_d;
    end
  end

  // Lanes show the fresh entry in the same cycle as the note_valid pulse
  assign note_lanes = note_valid ? rom_data[7:5] : lanes_q;
  assign rom_addr   = addr_q;
  assign note_idx   = idx_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_song_player_ctrl.sv
`default_nettype none
// ============================================================================
// tb_song_player_ctrl : directed vectors and timed sequences for song_player_ctrl
// Revision 1.0
// ============================================================================
module tb_song_player_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] song_id = 2'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       note_valid;
  logic [2:0] note_lanes;
  logic       busy;
  logic       finish;
  logic [1:0] note_idx;

  song_player_ctrl #(.TICK_DIV(4), .ROM_AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .song_id    (song_id),
    .pause      (pause),
    .abort      (abort),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_valid (note_valid),
    .note_lanes (note_lanes),
    .busy       (busy),
    .finish     (finish),
    .note_idx   (note_idx)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic       start;
    logic [1:0] song;
    logic       busy;
    logic       nv;
    logic [2:0] lanes;
    logic       fin;
    logic [1:0] idx;
    logic [3:0] addr;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic s, input logic [1:0] sg, input logic b,
                              input logic n, input logic [2:0] l, input logic f,
                              input logic [1:0] ix, input logic [3:0] a);
    vec_t v;
    v = {s, sg, b, n, l, f, ix, a};
    return v;
  endfunction

  // Results of one play() run
  int         nv_cyc [8];
  logic [2:0] nv_ln  [8];
  int         nv_ix  [8];
  int         n_nv, fin_cnt, fin_cyc, idle_cyc, max_idx, wrap;
  logic [2:0] idle_lanes;

  task automatic play(input logic [1:0] song, input int p0, input int plen,
                      input int ab, input int s2, input int maxc);
    int seen_nz;
    n_nv = 0; fin_cnt = 0; fin_cyc = -1; idle_cyc = -1; max_idx = 0; wrap = 0;
    seen_nz = 0; idle_lanes = 3'b111;
    for (int c = 0; c < maxc; c++) begin
      start   = (c == 0) || (c == s2);
      song_id = (c == 0) ? song : 2'd2;
      pause   = (c >= p0) && (c < p0 + plen);
      abort   = (c == ab);
      #1;
      if (note_valid) begin
        if (n_nv < 8) begin
          nv_cyc[n_nv] = c;
          nv_ln[n_nv]  = note_lanes;
          nv_ix[n_nv]  = int'(note_idx);
        end
        n_nv++;
      end
      if (finish) begin
        fin_cnt++;
        fin_cyc = c;
      end
      if (busy && int'(note_idx) > max_idx) max_idx = int'(note_idx);
      if (busy && rom_addr[1:0] != 2'd0) seen_nz = 1;
      if (busy && seen_nz != 0 && rom_addr[1:0] == 2'd0) wrap = 1;
      if (c > 0 && !busy) begin
        idle_cyc   = c;
        idle_lanes = note_lanes;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0; song_id = 2'd0;
    chk("play_terminates", int'(idle_cyc >= 0), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[4]  = 8'h22; rom[5]  = 8'h41; rom[6]  = 8'h00;
    rom[8]  = 8'h21; rom[9]  = 8'h41; rom[10] = 8'h81; rom[11] = 8'h61;
    rom[12] = 8'h20; rom[13] = 8'h02; rom[14] = 8'h00;

    tbl[0]  = mk(1'b1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 4'd0);
    tbl[1]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 4'd4);
    tbl[2]  = mk(1'b0, 2'd0, 1'b1, 1'b1, 3'd1, 1'b0, 2'd0, 4'd4);
    for (int i = 3; i <= 10; i++) tbl[i] = mk(1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 1'b0, 2'd0, 4'd4);
    tbl[5].start = 1'b1;
    tbl[5].song  = 2'd2;
    tbl[11] = mk(1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 1'b0, 2'd1, 4'd5);
    tbl[12] = mk(1'b0, 2'd0, 1'b1, 1'b1, 3'd2, 1'b0, 2'd1, 4'd5);
    for (int i = 13; i <= 16; i++) tbl[i] = mk(1'b0, 2'd0, 1'b1, 1'b0, 3'd2, 1'b0, 2'd1, 4'd5);
    tbl[17] = mk(1'b0, 2'd0, 1'b1, 1'b0, 3'd2, 1'b0, 2'd2, 4'd6);
    tbl[18] = mk(1'b0, 2'd0, 1'b1, 1'b0, 3'd2, 1'b0, 2'd2, 4'd6);
    tbl[19] = mk(1'b0, 2'd0, 1'b1, 1'b0, 3'd2, 1'b1, 2'd2, 4'd6);
    tbl[20] = mk(1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 4'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_idx", int'(note_idx), 0);
    chk("rst_lanes", int'(note_lanes), 0);
    chk("rst_nv", int'(note_valid), 0);
    chk("rst_finish", int'(finish), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Song 1 cycle by cycle; row 5 carries an ignored start for song 2
    for (int i = 0; i < 21; i++) begin
      start   = tbl[i].start;
      song_id = tbl[i].song;
      #1;
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_nv", i), int'(note_valid), int'(tbl[i].nv));
      chk($sformatf("tbl%0d_lanes", i), int'(note_lanes), int'(tbl[i].lanes));
      chk($sformatf("tbl%0d_finish", i), int'(finish), int'(tbl[i].fin));
      if (tbl[i].busy) begin
        chk($sformatf("tbl%0d_idx", i), int'(note_idx), int'(tbl[i].idx));
        chk($sformatf("tbl%0d_addr", i), int'(rom_addr), int'(tbl[i].addr));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    song_id = 2'd0;

    // start with song 0 is ignored and leaves rom_addr at the last song-1 address
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("song0_busy_c%0d", c), int'(busy), 0);
      chk($sformatf("song0_nv_c%0d", c), int'(note_valid), 0);
      chk($sformatf("song0_addr_c%0d", c), int'(rom_addr), 6);
      @(posedge clk); #1;
      start = 1'b0;
    end

    // Pause for 10 cycles inside the first 2-tick note
    play(2'd1, 5, 10, -1, -1, 60);
    chk("pause_n_nv", n_nv, 2);
    chk("pause_nv0", nv_cyc[0], 2);
    chk("pause_nv1", nv_cyc[1], 22);
    chk("pause_fin", fin_cyc, 29);
    chk("pause_fin_cnt", fin_cnt, 1);

    // Abort during the second note's HOLD
    play(2'd1, 1000, 0, 14, -1, 60);
    chk("abort_n_nv", n_nv, 2);
    chk("abort_fin_cnt", fin_cnt, 0);
    chk("abort_idle_cyc", idle_cyc, 15);
    chk("abort_idle_lanes", int'(idle_lanes), 0);

    // Replay after abort starts from index 0
    play(2'd1, 1000, 0, -1, -1, 60);
    chk("replay_n_nv", n_nv, 2);
    chk("replay_nv0", nv_cyc[0], 2);
    chk("replay_idx0", nv_ix[0], 0);
    chk("replay_ln0", int'(nv_ln[0]), 1);
    chk("replay_nv1", nv_cyc[1], 12);
    chk("replay_ln1", int'(nv_ln[1]), 2);
    chk("replay_fin", fin_cyc, 19);
    chk("replay_idle", idle_cyc, 20);

    // Chart without end marker: four notes, stop at last index
    play(2'd2, 1000, 0, -1, -1, 60);
    chk("full_n_nv", n_nv, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("full_nv%0d", k), nv_cyc[k], 2 + 6 * k);
    chk("full_ln0", int'(nv_ln[0]), 1);
    chk("full_ln1", int'(nv_ln[1]), 2);
    chk("full_ln2", int'(nv_ln[2]), 4);
    chk("full_ln3", int'(nv_ln[3]), 3);
    chk("full_max_idx", max_idx, 3);
    chk("full_wrap", wrap, 0);
    chk("full_fin", fin_cyc, 25);
    chk("full_fin_cnt", fin_cnt, 1);

    // Zero-duration note, a rest, start+abort together in IDLE, start while busy
    play(2'd3, 1000, 0, 0, 4, 60);
    chk("s3_n_nv", n_nv, 2);
    chk("s3_nv0", nv_cyc[0], 2);
    chk("s3_ln0", int'(nv_ln[0]), 1);
    chk("s3_nv1", nv_cyc[1], 8);
    chk("s3_ln1", int'(nv_ln[1]), 0);
    chk("s3_fin", fin_cyc, 19);
    chk("s3_idle", idle_cyc, 20);

    // Reset in the middle of a note
    start = 1'b1;
    song_id = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    song_id = 2'd0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_lanes", int'(note_lanes), 0);
    chk("midrst_addr", int'(rom_addr), 0);
    chk("midrst_idx", int'(note_idx), 0);
    chk("midrst_finish", int'(finish), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst_busy_c%0d", c), int'(busy), 0);
      chk($sformatf("postrst_finish_c%0d", c), int'(finish), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
